// File: rtl/fetch_sequencer_pkg.sv
// Shared control definitions for fetch_sequencer: opcodes, ALU encodings, FSM states, IR field positions.
// FETCH_SEQUENCER_STEP_EN adds the WAIT_STEP state to the state enum.
package ctrl_pkg;

    localparam logic [3:0] OP_HALT = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_SHL = 2'b10;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int WR_MSB  = 27;
    localparam int WR_LSB  = 23;
    localparam int RS_MSB  = 22;
    localparam int RS_LSB  = 18;
    localparam int RT_MSB  = 17;
    localparam int RT_LSB  = 13;
    localparam int IMM_MSB = 17;
    localparam int IMM_LSB = 0;

`ifdef FETCH_SEQUENCER_STEP_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_WRITEBACK, ST_HALT, ST_WAIT_STEP
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_WRITEBACK, ST_HALT
    } state_e;
`endif

    function automatic logic [3:0] opcode_of(input logic [31:0] ir);
        return ir[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// ROM, register-file and ALU control bundle between fetch_sequencer (master) and its environment (slave).
// FETCH_SEQUENCER_STEP_EN adds the step / step_wait pair.
interface fetch_sequencer_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
);
    logic               start;
    logic [INSTR_W-1:0] instruction;
    logic [PC_W-1:0]    pc;
    logic [4:0]         rs_addr;
    logic [4:0]         rt_addr;
    logic [4:0]         wr_addr;
    logic [31:0]        imm;
    logic [1:0]         alu_op;
    logic               alu_src_imm;
    logic               reg_write;
    logic               busy;
    logic               halted;
    logic               illegal;
`ifdef FETCH_SEQUENCER_STEP_EN
    logic               step;
    logic               step_wait;

    modport master (
        input  start, instruction, step,
        output pc, rs_addr, rt_addr, wr_addr, imm, alu_op, alu_src_imm,
               reg_write, busy, halted, illegal, step_wait
    );
    modport slave (
        output start, instruction, step,
        input  pc, rs_addr, rt_addr, wr_addr, imm, alu_op, alu_src_imm,
               reg_write, busy, halted, illegal, step_wait
    );
`else
    modport master (
        input  start, instruction,
        output pc, rs_addr, rt_addr, wr_addr, imm, alu_op, alu_src_imm,
               reg_write, busy, halted, illegal
    );
    modport slave (
        output start, instruction,
        input  pc, rs_addr, rt_addr, wr_addr, imm, alu_op, alu_src_imm,
               reg_write, busy, halted, illegal
    );
`endif
endinterface

// File: rtl/fetch_sequencer_decoder.sv
// instr_decoder: combinational opcode -> ALU control plus halt/illegal classification.
module instr_decoder
    import ctrl_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic [1:0] alu_op_o,
    output logic       alu_src_imm_o,
    output logic       is_halt_o,
    output logic       is_illegal_o
);

    always_comb begin
        alu_op_o      = ALU_ADD;
        alu_src_imm_o = 1'b0;
        is_halt_o     = 1'b0;
        is_illegal_o  = 1'b0;
        case (opcode_i)
            OP_ADDI: alu_src_imm_o = 1'b1;
            OP_ADD:  alu_op_o      = ALU_ADD;
            OP_SUBI: begin
                alu_op_o      = ALU_SUB;
                alu_src_imm_o = 1'b1;
            end
            OP_SHL:  alu_op_o      = ALU_SHL;
            OP_HALT: is_halt_o     = 1'b1;
            default: is_illegal_o  = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer owning the PC and IR.
// FETCH_SEQUENCER_STEP_EN: park in WAIT_STEP after every writeback until step is seen.
module fetch_sequencer
    import ctrl_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32,
    parameter int LAST_PC = 255
) (
    input  logic                clk,
    input  logic                rst,
    fetch_sequencer_if.master   bus
);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [1:0]         alu_op_q, alu_op_d;
    logic               alu_src_imm_q, alu_src_imm_d;
    logic               illegal_q, illegal_d;

    logic [1:0]         dec_alu_op;
    logic               dec_alu_src_imm;
    logic               dec_is_halt;
    logic               dec_is_illegal;

    instr_decoder u_decoder (
        .opcode_i      (opcode_of(ir_q)),
        .alu_op_o      (dec_alu_op),
        .alu_src_imm_o (dec_alu_src_imm),
        .is_halt_o     (dec_is_halt),
        .is_illegal_o  (dec_is_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            ir_q          <= '0;
            alu_op_q      <= ALU_ADD;
            alu_src_imm_q <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            alu_op_q      <= alu_op_d;
            alu_src_imm_q <= alu_src_imm_d;
            illegal_q     <= illegal_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        alu_op_d      = alu_op_q;
        alu_src_imm_d = alu_src_imm_q;
        illegal_d     = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_d    = bus.instruction;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                alu_op_d      = dec_alu_op;
                alu_src_imm_d = dec_alu_src_imm;
                if (dec_is_halt) begin
                    state_d = ST_HALT;
                end else if (dec_is_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: state_d = ST_WRITEBACK;
            ST_WRITEBACK: begin
                // The last ROM word halts in place rather than wrapping to 0.
                if (pc_q == PC_W'(LAST_PC)) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d = pc_q + 1'b1;
`ifdef FETCH_SEQUENCER_STEP_EN
                    state_d = ST_WAIT_STEP;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
`ifdef FETCH_SEQUENCER_STEP_EN
            ST_WAIT_STEP: begin
                if (bus.step) state_d = ST_FETCH;
            end
`endif
            ST_HALT: begin
                if (bus.start) begin
                    pc_d      = '0;
                    illegal_d = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.wr_addr     = ir_q[WR_MSB:WR_LSB];
    assign bus.rs_addr     = ir_q[RS_MSB:RS_LSB];
    assign bus.rt_addr     = ir_q[RT_MSB:RT_LSB];
    assign bus.imm         = 32'(ir_q[IMM_MSB:IMM_LSB]);
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_src_imm = alu_src_imm_q;
    // Gated with rst so a writeback coinciding with reset never reaches the register file.
    assign bus.reg_write   = (state_q == ST_WRITEBACK) && !rst;
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.illegal     = illegal_q;
`ifdef FETCH_SEQUENCER_STEP_EN
    assign bus.step_wait   = (state_q == ST_WAIT_STEP);
    assign bus.busy        = state_q inside {ST_FETCH, ST_DECODE, ST_EXECUTE, ST_WRITEBACK, ST_WAIT_STEP};
`else
    assign bus.busy        = state_q inside {ST_FETCH, ST_DECODE, ST_EXECUTE, ST_WRITEBACK};
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: dut0 uses the full ROM, dut1 has LAST_PC=3.
// FETCH_SEQUENCER_STEP_EN adds a single-step scenario.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rom0 [0:255];
    logic [31:0] rom1 [0:255];

    fetch_sequencer_if #(.PC_W(8), .INSTR_W(32)) bus0 ();
    fetch_sequencer_if #(.PC_W(8), .INSTR_W(32)) bus1 ();

    assign bus0.instruction = rom0[bus0.pc];
    assign bus1.instruction = rom1[bus1.pc];

    fetch_sequencer #(.PC_W(8), .INSTR_W(32), .LAST_PC(255)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fetch_sequencer #(.PC_W(8), .INSTR_W(32), .LAST_PC(3))   dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
`ifdef FETCH_SEQUENCER_STEP_EN
        bus0.step = 1'b0;
        bus1.step = 1'b0;
`endif
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Move from WRITEBACK to the next FETCH (through WAIT_STEP when stepping is built in).
    task automatic after_wb(input int which);
`ifdef FETCH_SEQUENCER_STEP_EN
        tick;
        if (which == 0) bus0.step = 1'b1; else bus1.step = 1'b1;
        tick;
        bus0.step = 1'b0;
        bus1.step = 1'b0;
`else
        tick;
`endif
    endtask

    task automatic clear_rom0;
        for (int i = 0; i < 256; i++) rom0[i] = 32'h0;
    endtask

    task automatic test_reset;
        clear_rom0();
        rom0[0] = 32'h1100000A;
        rst = 1'b1;
        bus0.start = 1'b1;
        tick;
        tick;
        n_cmp++; if (bus0.pc !== 8'd0) begin n_err++; $display("FAIL reset_pc: got %0d want 0", bus0.pc); end
        n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus0.busy); end
        n_cmp++; if (bus0.halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", bus0.halted); end
        n_cmp++; if (bus0.illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal: got %b want 0", bus0.illegal); end
        n_cmp++; if (bus0.reg_write !== 1'b0) begin n_err++; $display("FAIL reset_reg_write: got %b want 0", bus0.reg_write); end
        n_cmp++; if (bus0.alu_op !== 2'b00) begin n_err++; $display("FAIL reset_alu_op: got %b want 00", bus0.alu_op); end
        n_cmp++; if (bus0.alu_src_imm !== 1'b0) begin n_err++; $display("FAIL reset_alu_src_imm: got %b want 0", bus0.alu_src_imm); end
        n_cmp++; if (bus0.imm !== 32'd0 || bus0.wr_addr !== 5'd0) begin n_err++; $display("FAIL reset_ir: imm %h wr %0d want 0 0", bus0.imm, bus0.wr_addr); end
        rst = 1'b0;
        bus0.start = 1'b0;
        tick;
        n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL idle_stays: busy %b want 0", bus0.busy); end
        $display("test_reset done");
    endtask

    task automatic test_addi;
        clear_rom0();
        rom0[0] = 32'h1100000A;
        do_reset();
        bus0.start = 1'b1;
        tick;
        bus0.start = 1'b0;
        n_cmp++; if (bus0.busy !== 1'b1 || bus0.reg_write !== 1'b0) begin n_err++; $display("FAIL addi_fetch: busy %b rw %b want 1 0", bus0.busy, bus0.reg_write); end
        tick;
        n_cmp++; if (bus0.wr_addr !== 5'd2 || bus0.rs_addr !== 5'd0 || bus0.imm !== 32'd10) begin
            n_err++; $display("FAIL addi_decode: wr %0d rs %0d imm %0d want 2 0 10", bus0.wr_addr, bus0.rs_addr, bus0.imm); end
        n_cmp++; if (bus0.reg_write !== 1'b0) begin n_err++; $display("FAIL addi_rw_decode: got %b want 0", bus0.reg_write); end
        tick;
        n_cmp++; if (bus0.alu_src_imm !== 1'b1 || bus0.alu_op !== 2'b00) begin
            n_err++; $display("FAIL addi_alu: src %b op %b want 1 00", bus0.alu_src_imm, bus0.alu_op); end
        n_cmp++; if (bus0.reg_write !== 1'b0) begin n_err++; $display("FAIL addi_rw_execute: got %b want 0", bus0.reg_write); end
        tick;
        n_cmp++; if (bus0.reg_write !== 1'b1 || bus0.pc !== 8'd0) begin n_err++; $display("FAIL addi_wb: rw %b pc %0d want 1 0", bus0.reg_write, bus0.pc); end
        after_wb(0);
        n_cmp++; if (bus0.pc !== 8'd1 || bus0.reg_write !== 1'b0) begin n_err++; $display("FAIL addi_next_pc: pc %0d rw %b want 1 0", bus0.pc, bus0.reg_write); end
        tick;
        tick;
        n_cmp++; if (bus0.halted !== 1'b1 || bus0.pc !== 8'd1 || bus0.illegal !== 1'b0) begin
            n_err++; $display("FAIL addi_halt: halted %b pc %0d illegal %b want 1 1 0", bus0.halted, bus0.pc, bus0.illegal); end
        $display("test_addi done: ir word 1100000A");
    endtask

    task automatic test_program;
        logic [31:0] prog [0:6];
        int pulses;
        prog = '{32'h1100000A, 32'h2CA9E000, 32'h30840003, 32'h10000001, 32'h4F64A000, 32'h20000000, 32'h00000000};
        pulses = 0;
        clear_rom0();
        for (int i = 0; i < 7; i++) rom0[i] = prog[i];
        do_reset();
        bus0.start = 1'b1;
        tick;
        bus0.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (bus0.pc !== 8'(i)) begin n_err++; $display("FAIL prog_pc: got %0d want %0d", bus0.pc, i); end
            tick;
            if (i == 1) begin
                n_cmp++; if (bus0.wr_addr !== 5'd25 || bus0.rs_addr !== 5'd10 || bus0.rt_addr !== 5'd15) begin
                    n_err++; $display("FAIL prog_fields: wr %0d rs %0d rt %0d want 25 10 15", bus0.wr_addr, bus0.rs_addr, bus0.rt_addr); end
            end
            if (i == 2) bus0.start = 1'b1;
            tick;
            bus0.start = 1'b0;
            if (i == 1) begin
                n_cmp++; if (bus0.alu_src_imm !== 1'b0) begin n_err++; $display("FAIL prog_add_src: got %b want 0", bus0.alu_src_imm); end
            end
            if (i == 4) begin
                n_cmp++; if (bus0.alu_op !== 2'b10) begin n_err++; $display("FAIL prog_shl_op: got %b want 10", bus0.alu_op); end
            end
            n_cmp++; if (bus0.reg_write !== 1'b0) begin n_err++; $display("FAIL prog_rw_execute: got %b want 0 at pc %0d", bus0.reg_write, bus0.pc); end
            tick;
            if (bus0.reg_write === 1'b1) pulses++;
            $display("prog instr pc=%0d wr=%0d alu_op=%b src_imm=%b reg_write=%b",
                     bus0.pc, bus0.wr_addr, bus0.alu_op, bus0.alu_src_imm, bus0.reg_write);
            after_wb(0);
        end
        n_cmp++; if (bus0.pc !== 8'd6) begin n_err++; $display("FAIL prog_pc_end: got %0d want 6", bus0.pc); end
        tick;
        tick;
        n_cmp++; if (bus0.halted !== 1'b1 || bus0.busy !== 1'b0 || bus0.pc !== 8'd6) begin
            n_err++; $display("FAIL prog_halt: halted %b busy %b pc %0d want 1 0 6", bus0.halted, bus0.busy, bus0.pc); end
        n_cmp++; if (pulses !== 6) begin n_err++; $display("FAIL prog_pulses: got %0d want 6", pulses); end
    endtask

    task automatic test_illegal;
        clear_rom0();
        for (int i = 0; i < 3; i++) rom0[i] = 32'h1100000A;
        rom0[3] = 32'hF0000000;
        do_reset();
        bus0.start = 1'b1;
        tick;
        bus0.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            tick;
            tick;
            n_cmp++; if (bus0.reg_write !== 1'b1) begin n_err++; $display("FAIL illegal_pre_rw: got %b want 1 at %0d", bus0.reg_write, i); end
            after_wb(0);
        end
        n_cmp++; if (bus0.pc !== 8'd3) begin n_err++; $display("FAIL illegal_pc: got %0d want 3", bus0.pc); end
        tick;
        tick;
        n_cmp++; if (bus0.halted !== 1'b1 || bus0.illegal !== 1'b1 || bus0.reg_write !== 1'b0 || bus0.pc !== 8'd3) begin
            n_err++; $display("FAIL illegal_halt: halted %b illegal %b rw %b pc %0d want 1 1 0 3",
                              bus0.halted, bus0.illegal, bus0.reg_write, bus0.pc); end
        tick;
        tick;
        n_cmp++; if (bus0.illegal !== 1'b1 || bus0.reg_write !== 1'b0 || bus0.pc !== 8'd3) begin
            n_err++; $display("FAIL illegal_sticky: illegal %b rw %b pc %0d want 1 0 3", bus0.illegal, bus0.reg_write, bus0.pc); end
        bus0.start = 1'b1;
        tick;
        bus0.start = 1'b0;
        n_cmp++; if (bus0.pc !== 8'd0 || bus0.illegal !== 1'b0 || bus0.halted !== 1'b0 || bus0.busy !== 1'b1) begin
            n_err++; $display("FAIL illegal_restart: pc %0d illegal %b halted %b busy %b want 0 0 0 1",
                              bus0.pc, bus0.illegal, bus0.halted, bus0.busy); end
        $display("test_illegal done");
    endtask

    task automatic test_last_pc;
        do_reset();
        bus1.start = 1'b1;
        tick;
        bus1.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus1.pc !== 8'(i)) begin n_err++; $display("FAIL last_pc_step: got %0d want %0d", bus1.pc, i); end
            tick;
            tick;
            tick;
            n_cmp++; if (bus1.reg_write !== 1'b1) begin n_err++; $display("FAIL last_pc_rw: got %b want 1 at %0d", bus1.reg_write, i); end
            if (i < 3) after_wb(1); else tick;
        end
        n_cmp++; if (bus1.halted !== 1'b1 || bus1.pc !== 8'd3 || bus1.busy !== 1'b0) begin
            n_err++; $display("FAIL last_pc_halt: halted %b pc %0d busy %b want 1 3 0", bus1.halted, bus1.pc, bus1.busy); end
        tick;
        tick;
        tick;
        n_cmp++; if (bus1.pc !== 8'd3 || bus1.reg_write !== 1'b0) begin n_err++; $display("FAIL last_pc_nowrap: pc %0d rw %b want 3 0", bus1.pc, bus1.reg_write); end
        $display("test_last_pc done");
    endtask

    task automatic test_reset_in_wb;
        clear_rom0();
        rom0[0] = 32'h1100000A;
        rom0[1] = 32'h30840003;
        do_reset();
        bus0.start = 1'b1;
        tick;
        bus0.start = 1'b0;
        tick;
        tick;
        tick;
        after_wb(0);
        bus0.start = 1'b1;
        tick;
        bus0.start = 1'b0;
        n_cmp++; if (bus0.pc !== 8'd1 || bus0.busy !== 1'b1) begin n_err++; $display("FAIL busy_start_ignored: pc %0d busy %b want 1 1", bus0.pc, bus0.busy); end
        tick;
        tick;
        n_cmp++; if (bus0.reg_write !== 1'b1) begin n_err++; $display("FAIL rst_wb_pre: rw %b want 1", bus0.reg_write); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus0.reg_write !== 1'b0) begin n_err++; $display("FAIL rst_wb_suppress: rw %b want 0", bus0.reg_write); end
        tick;
        n_cmp++; if (bus0.busy !== 1'b0 || bus0.pc !== 8'd0 || bus0.halted !== 1'b0 || bus0.reg_write !== 1'b0) begin
            n_err++; $display("FAIL rst_wb_state: busy %b pc %0d halted %b rw %b want 0 0 0 0",
                              bus0.busy, bus0.pc, bus0.halted, bus0.reg_write); end
        rst = 1'b0;
        tick;
        n_cmp++; if (bus0.busy !== 1'b0 || bus0.pc !== 8'd0 || bus0.alu_op !== 2'b00) begin
            n_err++; $display("FAIL rst_wb_idle: busy %b pc %0d op %b want 0 0 00", bus0.busy, bus0.pc, bus0.alu_op); end
        $display("test_reset_in_wb done");
    endtask

`ifdef FETCH_SEQUENCER_STEP_EN
    task automatic test_step;
        clear_rom0();
        for (int i = 0; i < 4; i++) rom0[i] = 32'h1100000A;
        do_reset();
        bus0.start = 1'b1;
        tick;
        bus0.start = 1'b0;
        tick;
        tick;
        tick;
        tick;
        n_cmp++; if (bus0.step_wait !== 1'b1 || bus0.busy !== 1'b1 || bus0.pc !== 8'd1) begin
            n_err++; $display("FAIL step_wait_enter: sw %b busy %b pc %0d want 1 1 1", bus0.step_wait, bus0.busy, bus0.pc); end
        for (int i = 0; i < 10; i++) tick;
        n_cmp++; if (bus0.step_wait !== 1'b1 || bus0.pc !== 8'd1 || bus0.reg_write !== 1'b0) begin
            n_err++; $display("FAIL step_hold: sw %b pc %0d rw %b want 1 1 0", bus0.step_wait, bus0.pc, bus0.reg_write); end
        bus0.step = 1'b1;
        tick;
        bus0.step = 1'b0;
        n_cmp++; if (bus0.step_wait !== 1'b0 || bus0.pc !== 8'd1) begin n_err++; $display("FAIL step_go: sw %b pc %0d want 0 1", bus0.step_wait, bus0.pc); end
        tick;
        tick;
        tick;
        tick;
        n_cmp++; if (bus0.step_wait !== 1'b1 || bus0.pc !== 8'd2) begin n_err++; $display("FAIL step_one: sw %b pc %0d want 1 2", bus0.step_wait, bus0.pc); end
        $display("test_step done");
    endtask
`endif

    initial begin
        bus0.start = 1'b0;
        bus1.start = 1'b0;
`ifdef FETCH_SEQUENCER_STEP_EN
        bus0.step = 1'b0;
        bus1.step = 1'b0;
`endif
        for (int i = 0; i < 256; i++) rom1[i] = 32'h1100000A;
        test_reset();
        test_addi();
        test_program();
        test_illegal();
        test_last_pc();
        test_reset_in_wb();
`ifdef FETCH_SEQUENCER_STEP_EN
        test_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle control unit for the 8-bit-PC, 32-bit-instruction core.
- Owns the PC and drives the combinational instruction ROM (PC out, instruction in).
- Latches each instruction into an internal IR, decodes it, and sequences the register file and ALU through fixed FETCH/DECODE/EXECUTE/WRITEBACK steps.
- Runs until a HALT opcode, an illegal opcode, or the end of ROM.

Parameters:
- PC_W, 8, PC width; ROM depth is 2**PC_W.
- INSTR_W, 32, instruction width.
- LAST_PC, 255, final executable address; after its writeback the block halts instead of wrapping.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution from PC 0 when in IDLE or HALT.
- instruction  in  INSTR_W  ROM data for the current pc (combinational, same cycle).
- pc  out  PC_W  ROM address.
- rs_addr  out  5  register-file read port A, IR[22:18].
- rt_addr  out  5  register-file read port B, IR[17:13].
- wr_addr  out  5  register-file write address, IR[27:23].
- imm  out  32  IR[17:0] zero-extended.
- alu_op  out  2  ALU function: 00 ADD, 01 SUB, 10 SHL.
- alu_src_imm  out  1  1 selects imm as ALU operand B, 0 selects rt data.
- reg_write  out  1  register-file write strobe.
- busy  out  1  high in FETCH, DECODE, EXECUTE, WRITEBACK.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set when HALT was entered through an unknown opcode.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, pc=0, IR=0, reg_write=0, busy=0, halted=0, illegal=0, alu_op=00, alu_src_imm=0.
- Opcode map (IR[31:28]):
  - 0001 ADDI: alu_op=00, imm operand.
  - 0010 ADD: alu_op=00, reg operand.
  - 0011 SUBI: alu_op=01, imm operand.
  - 0100 SHL: alu_op=10, reg operand.
  - 0000 HALT.
  - All other opcodes are illegal.
- IDLE: wait; start=1 -> FETCH.
- FETCH (1 cycle): IR <= instruction; -> DECODE.
- DECODE (1 cycle): register decode outputs from IR.
  - HALT opcode -> HALT.
  - Illegal opcode -> HALT with illegal <= 1.
  - Otherwise -> EXECUTE.
- EXECUTE (1 cycle): decode outputs held stable so ALU and register-file reads settle; -> WRITEBACK.
- WRITEBACK (1 cycle): reg_write=1 for exactly this cycle.
  - If pc==LAST_PC: pc unchanged, -> HALT.
  - Otherwise pc <= pc+1, -> FETCH.
- Throughput and latency:
  - 4 cycles per instruction; 1st instruction's reg_write is asserted 4 cycles after the start-capture edge.
  - No wrap-around past LAST_PC.
- Field and decode-output rules:
  - rs_addr, rt_addr, wr_addr and imm are continuous slices of IR; they are valid from DECODE through WRITEBACK.
  - reg_write is never high outside WRITEBACK; writes to r0 are still issued (the register file ignores them).
  - alu_op and alu_src_imm are registered in DECODE and hold until the next DECODE.
- HALT: busy=0, halted=1, pc frozen.
  - start=1 -> pc<=0, halted<=0, illegal<=0, -> FETCH.
- start while busy is ignored.
- rst asserted in any state overrides everything:
  - Outputs take reset values on the next edge.
  - A reg_write pending in that cycle is suppressed.

Optional Feature:
- Macro: FETCH_SEQUENCER_STEP_EN.
- Defined: adds input step (1 bit) and output step_wait (1 bit).
  - After each WRITEBACK the FSM enters WAIT_STEP (step_wait=1, busy=1) instead of FETCH.
  - step=1 -> FETCH. The HALT and LAST_PC rules are unchanged.
  - step is ignored in all other states.
- Undefined: no step port and no WAIT_STEP state; free-running as above.

Decomposition:
- Shared package ctrl_pkg holds:
  - Opcode constants OP_HALT/OP_ADDI/OP_ADD/OP_SUBI/OP_SHL.
  - ALU_ADD/ALU_SUB/ALU_SHL encodings.
  - State enum encoding.
  - Field bit positions.
- One sub-module, instr_decoder: combinational IR -> {alu_op, alu_src_imm, is_halt, is_illegal}. The FSM stays in fetch_sequencer.

Test Plan:
- Reset, then start pulse, ROM mem0=0x1100000A (ADDI) -> IR=0x1100000A at DECODE; wr_addr=2, rs_addr=0, imm=10, alu_src_imm=1, alu_op=00; reg_write high exactly on the 4th cycle after start; pc=1 next.
- 6-instruction program followed by 0x00000000:
  - pc steps 0..6.
  - Instruction 2 (0x2CA9E000): wr_addr=25, rs_addr=10, rt_addr=15, alu_src_imm=0.
  - Instruction 5 (0x4F64A000): alu_op=10.
  - halted=1 after pc=6 DECODE; 6 reg_write pulses total.
- Opcode 0xF at pc=3 -> halted=1, illegal=1, no reg_write for that instruction, pc stays 3; start -> pc=0, illegal=0.
- LAST_PC=3 with no HALT word -> after pc=3 WRITEBACK, halted=1 and pc=3 (no wrap to 0).
- rst asserted during WRITEBACK -> reg_write=0 that edge, next cycle state IDLE, pc=0; start pulses while busy have no effect.
- With FETCH_SEQUENCER_STEP_EN: step_wait=1 after each WRITEBACK; holding step=0 for 10 cycles keeps pc constant; one step pulse advances exactly one instruction.
